// File: rtl/uart_pkg.sv
// Shared definitions for the APB FIFO UART: register indices, STATUS/CTRL bit positions,
// oversampling ratio and the TX/RX state encodings.
// Ports: none (package).
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_BAUD   = 3'd3;
    localparam logic [2:0] REG_FLUSH  = 3'd4;

    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_OVERRUN      = 4;
    localparam int ST_FRAME_ERR    = 5;
    localparam int ST_TX_BUSY      = 6;
    localparam int ST_PARITY_ERR   = 7;
    localparam int ST_RX_COUNT_LSB = 8;

    localparam int CT_TX_EN    = 0;
    localparam int CT_RX_EN    = 1;
    localparam int CT_IE_RX    = 2;
    localparam int CT_IE_TX    = 3;
    localparam int CT_IE_ERR   = 4;
    localparam int CT_THR_LSB  = 8;
    localparam int CT_PAR_LSB  = 12;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Ports: clk_i/rst_i (async active-high), push_i/din_i, pop_i/dout_o (head, valid when !empty_o),
//        flush_i (wins over a same-cycle push), full_o, empty_o, count_o.
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so push-while-full succeeds when paired with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB UART with TX/RX FIFOs, 16x oversampled receiver with false-start rejection,
// threshold RX interrupt, sticky error flags and FIFO flush.
// Ports: PCLK, PRESET (async active-high), APB slave (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA),
//        RXD serial in (asynchronous), TXD serial out, irq registered interrupt.
// Optional parity generation/checking is compiled in with `define UART_PARITY_EN.
module uart_apb_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1,
    parameter int DIV_RESET  = 26
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [2:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    input  logic        RXD,
    output logic        TXD,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- APB decode ----------------
    logic apb_wr, apb_rd;
    logic wr_data, wr_ctrl, wr_baud, wr_flush, rd_data, rd_status;
    logic unused_pwdata;

    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign wr_data   = apb_wr && (PADDR == REG_DATA);
    assign wr_ctrl   = apb_wr && (PADDR == REG_CTRL);
    assign wr_baud   = apb_wr && (PADDR == REG_BAUD);
    assign wr_flush  = apb_wr && (PADDR == REG_FLUSH);
    assign rd_data   = apb_rd && (PADDR == REG_DATA);
    assign rd_status = apb_rd && (PADDR == REG_STATUS);
    assign unused_pwdata = ^PWDATA[31:16];

    // ---------------- Control registers ----------------
    logic       tx_en_q, rx_en_q, ie_rx_q, ie_tx_q, ie_err_q;
    logic [3:0] thr_q;
    logic       par_on, par_odd;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_en_q  <= 1'b0;
            rx_en_q  <= 1'b0;
            ie_rx_q  <= 1'b0;
            ie_tx_q  <= 1'b0;
            ie_err_q <= 1'b0;
            thr_q    <= 4'd0;
        end else if (wr_ctrl) begin
            tx_en_q  <= PWDATA[CT_TX_EN];
            rx_en_q  <= PWDATA[CT_RX_EN];
            ie_rx_q  <= PWDATA[CT_IE_RX];
            ie_tx_q  <= PWDATA[CT_IE_TX];
            ie_err_q <= PWDATA[CT_IE_ERR];
            thr_q    <= PWDATA[CT_THR_LSB +: 4];
        end
    end

`ifdef UART_PARITY_EN
    logic [1:0] par_q;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)       par_q <= 2'b00;
        else if (wr_ctrl) par_q <= PWDATA[CT_PAR_LSB +: 2];
    end
    // 01 odd, 10 even; 00 and 11 both mean no parity bit.
    assign par_on  = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_odd = (par_q == 2'b01);
`else
    assign par_on  = 1'b0;
    assign par_odd = 1'b0;
`endif

    // ---------------- Baud tick ----------------
    logic [15:0] div_q, bcnt_q;
    logic        tick;

    assign tick = (bcnt_q == div_q);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            div_q  <= 16'(DIV_RESET);
            bcnt_q <= 16'd0;
        end else if (wr_baud) begin
            div_q  <= PWDATA[15:0];
            bcnt_q <= 16'd0;
        end else begin
            bcnt_q <= tick ? 16'd0 : bcnt_q + 16'd1;
        end
    end

    // ---------------- FIFOs ----------------
    logic              flush_rx, flush_tx;
    logic [DATA_W-1:0] tx_dout, rx_dout;
    logic              tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push_q;
    logic [CW-1:0]     rx_count, tx_count_unused;
    logic [DATA_W-1:0] rx_sh_q;

    assign flush_rx = wr_flush & PWDATA[0];
    assign flush_tx = wr_flush & PWDATA[1];

    uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(PCLK), .rst_i(PRESET),
        .push_i(wr_data), .din_i(PWDATA[DATA_W-1:0]),
        .pop_i(tx_pop), .flush_i(flush_tx),
        .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count_unused)
    );

    uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(PCLK), .rst_i(PRESET),
        .push_i(rx_push_q), .din_i(rx_sh_q),
        .pop_i(rd_data), .flush_i(flush_rx),
        .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    // ---------------- Transmitter ----------------
    tx_state_e         tx_st_q;
    logic [3:0]        tx_tck_q, tx_bit_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic              tx_par_q, txd_q;
    logic              tx_bit_end, tx_last_stop, tx_busy;

    assign tx_bit_end   = tick && (tx_tck_q == 4'(OVERSAMPLE - 1));
    assign tx_last_stop = (tx_bit_q == 4'(STOP_BITS - 1));
    assign tx_busy      = (tx_st_q != TX_IDLE);
    // Pop either from idle or at the very end of the last stop bit, so frames run back to back.
    assign tx_pop = tx_en_q && !tx_empty &&
                    ((tx_st_q == TX_IDLE) || (tx_st_q == TX_STOP && tx_bit_end && tx_last_stop));
    assign TXD = txd_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_st_q  <= TX_IDLE;
            tx_tck_q <= 4'd0;
            tx_bit_q <= 4'd0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            if (tx_st_q != TX_IDLE && tick) tx_tck_q <= tx_tck_q + 4'd1;
            case (tx_st_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_st_q  <= TX_START;
                        tx_tck_q <= 4'd0;
                        tx_sh_q  <= tx_dout;
                        tx_par_q <= (^tx_dout) ^ par_odd;
                        txd_q    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_st_q  <= TX_DATA;
                        tx_bit_q <= 4'd0;
                        txd_q    <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == 4'(DATA_W - 1)) begin
                            if (par_on) begin
                                tx_st_q <= TX_PARITY;
                                txd_q   <= tx_par_q;
                            end else begin
                                tx_st_q  <= TX_STOP;
                                tx_bit_q <= 4'd0;
                                txd_q    <= 1'b1;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                            txd_q    <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_st_q  <= TX_STOP;
                        tx_bit_q <= 4'd0;
                        txd_q    <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (!tx_last_stop) begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                        end else if (tx_pop) begin
                            tx_st_q  <= TX_START;
                            tx_sh_q  <= tx_dout;
                            tx_par_q <= (^tx_dout) ^ par_odd;
                            txd_q    <= 1'b0;
                        end else begin
                            tx_st_q <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    tx_st_q <= TX_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- Receiver ----------------
    logic       rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e  rx_st_q;
    logic [3:0] rx_tck_q, rx_bit_q;
    logic       rx_fall, rx_bit_end, rx_mid, ferr_set, perr_set;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= RXD;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    assign rx_fall    = rx_s3_q & ~rx_s2_q;
    assign rx_bit_end = tick && (rx_tck_q == 4'(OVERSAMPLE - 1));
    assign rx_mid     = tick && (rx_tck_q == 4'(OVERSAMPLE / 2 - 1));
    assign ferr_set   = rx_en_q && (rx_st_q == RX_STOP) && rx_bit_end && !rx_s2_q;
    assign perr_set   = rx_en_q && (rx_st_q == RX_PARITY) && rx_bit_end &&
                        (rx_s2_q != ((^rx_sh_q) ^ par_odd));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_st_q   <= RX_IDLE;
            rx_tck_q  <= 4'd0;
            rx_bit_q  <= 4'd0;
            rx_sh_q   <= '0;
            rx_push_q <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            if (!rx_en_q) begin
                rx_st_q <= RX_IDLE;
            end else begin
                if (rx_st_q != RX_IDLE && tick) rx_tck_q <= rx_tck_q + 4'd1;
                case (rx_st_q)
                    RX_IDLE: begin
                        if (rx_fall) begin
                            rx_st_q  <= RX_START;
                            rx_tck_q <= 4'd0;
                        end
                    end
                    RX_START: begin
                        // Start-bit centre: line back high means a glitch, not a frame.
                        if (rx_mid) begin
                            if (rx_s2_q) begin
                                rx_st_q <= RX_IDLE;
                            end else begin
                                rx_st_q  <= RX_DATA;
                                rx_tck_q <= 4'd0;
                                rx_bit_q <= 4'd0;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (rx_bit_end) begin
                            rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_W-1:1]};
                            if (rx_bit_q == 4'(DATA_W - 1))
                                rx_st_q <= par_on ? RX_PARITY : RX_STOP;
                            else
                                rx_bit_q <= rx_bit_q + 4'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_bit_end) rx_st_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (rx_bit_end) begin
                            rx_st_q   <= RX_IDLE;
                            rx_push_q <= rx_s2_q;
                        end
                    end
                    default: rx_st_q <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- Sticky flags and interrupt ----------------
    logic ovr_q, ferr_q, perr_flag, ovr_set, irq_q;
    logic [3:0] thr_eff;

    // A set in the same cycle as the clearing STATUS read survives, so no event is lost.
    assign ovr_set = rx_push_q & rx_full & ~rd_data & ~flush_rx;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= (ovr_q  & ~rd_status) | ovr_set;
            ferr_q <= (ferr_q & ~rd_status) | ferr_set;
        end
    end

`ifdef UART_PARITY_EN
    logic perr_q;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) perr_q <= 1'b0;
        else        perr_q <= (perr_q & ~rd_status) | perr_set;
    end
    assign perr_flag = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_set;
    assign perr_flag   = 1'b0;
`endif

    assign thr_eff = (thr_q == 4'd0) ? 4'd1 : thr_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) irq_q <= 1'b0;
        else        irq_q <= (ie_rx_q  & (8'(rx_count) >= 8'(thr_eff))) |
                             (ie_tx_q  & tx_empty & ~tx_busy) |
                             (ie_err_q & (ovr_q | ferr_q | perr_flag));
    end
    assign irq = irq_q;

    // ---------------- Read mux ----------------
    logic [31:0] status_rd, ctrl_rd;

    always_comb begin
        status_rd = '0;
        status_rd[ST_RX_NONEMPTY] = ~rx_empty;
        status_rd[ST_RX_FULL]     = rx_full;
        status_rd[ST_TX_EMPTY]    = tx_empty;
        status_rd[ST_TX_FULL]     = tx_full;
        status_rd[ST_OVERRUN]     = ovr_q;
        status_rd[ST_FRAME_ERR]   = ferr_q;
        status_rd[ST_TX_BUSY]     = tx_busy;
        status_rd[ST_PARITY_ERR]  = perr_flag;
        status_rd[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);

        ctrl_rd = '0;
        ctrl_rd[CT_TX_EN]  = tx_en_q;
        ctrl_rd[CT_RX_EN]  = rx_en_q;
        ctrl_rd[CT_IE_RX]  = ie_rx_q;
        ctrl_rd[CT_IE_TX]  = ie_tx_q;
        ctrl_rd[CT_IE_ERR] = ie_err_q;
        ctrl_rd[CT_THR_LSB +: 4] = thr_q;
`ifdef UART_PARITY_EN
        ctrl_rd[CT_PAR_LSB +: 2] = par_q;
`else
        ctrl_rd[CT_PAR_LSB +: 2] = 2'b00;
`endif

        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                REG_DATA:   PRDATA = rx_empty ? 32'd0 : 32'(rx_dout);
                REG_STATUS: PRDATA = status_rd;
                REG_CTRL:   PRDATA = ctrl_rd;
                REG_BAUD:   PRDATA = {16'd0, div_q};
                default:    PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_fifo.sv
`timescale 1ns/1ps
module tb_uart_apb_fifo;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [2:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        RXD, TXD, irq;
    logic        loop_en, rxd_drv;

    int checks   = 0;
    int failures = 0;
    int div_cur;

    // Reference model: RX FIFO contents and sticky flags.
    logic [7:0] rxq[$];
    logic       ovr_m, ferr_m;

    assign RXD = loop_en ? TXD : rxd_drv;
    always #5 PCLK = ~PCLK;

    uart_apb_fifo dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .RXD(RXD), .TXD(TXD), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(negedge PCLK); PENABLE = 1;
        @(negedge PCLK); PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(negedge PCLK); PENABLE = 1;
        #1 d = PRDATA;
        @(negedge PCLK); PSEL = 0; PENABLE = 0;
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = rxq.size();
        return {16'h0, 8'(n), 1'b0, 1'b0, ferr_m, ovr_m, 1'b0, 1'b1, (n == 16), (n != 0)};
    endfunction

    // STATUS check with TX idle; the read clears the sticky flags in the model too.
    task automatic status_check(input string tag);
        logic [31:0] d;
        apb_read(3'd1, d);
        check(tag, d, exp_status());
        ovr_m  = 1'b0;
        ferr_m = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok)             ferr_m = 1'b1;
        else if (rxq.size() < 16) rxq.push_back(b);
        else                      ovr_m = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        int bc;
        bc = 16 * (div_cur + 1);
        @(negedge PCLK); rxd_drv = 1'b0;
        repeat (bc) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (bc) @(negedge PCLK);
        end
        rxd_drv = stop_v;
        repeat (bc) @(negedge PCLK);
        rxd_drv = 1'b1;
        repeat (bc) @(negedge PCLK);
        model_rx(b, stop_v);
    endtask

    task automatic drain_check(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        while (rxq.size() != 0) begin
            e = rxq.pop_front();
            apb_read(3'd0, d);
            check(tag, d, {24'h0, e});
        end
    endtask

    task automatic wait_txd_low(input string tag);
        int n;
        n = 0;
        while (TXD !== 1'b0 && n < 60) begin
            @(negedge PCLK);
            n++;
        end
        check(tag, TXD, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [8:0]  frame;
        logic [7:0]  tx_bytes[3];

        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 3'd0; PWDATA = 32'd0;
        loop_en = 0; rxd_drv = 1; div_cur = 26; ovr_m = 0; ferr_m = 0;
        repeat (3) @(negedge PCLK);
        check("reset_txd", TXD, 1'b1);
        check("reset_irq", irq, 1'b0);
        PRESET = 0;
        repeat (2) @(negedge PCLK);
        check("idle_prdata", PRDATA, 32'd0);
        status_check("reset_status");
        apb_read(3'd2, d); check("reset_ctrl", d, 32'd0);
        apb_read(3'd3, d); check("reset_baud", d, 32'd26);
        apb_read(3'd5, d); check("undef_read", d, 32'd0);

        // ---- TX waveform of 0xA5 at one tick per cycle ----
        apb_write(3'd3, 32'd0); div_cur = 0;
        apb_write(3'd2, 32'h3);
        apb_write(3'd0, 32'hA5);
        wait_txd_low("tx_start_seen");
        repeat (15) @(negedge PCLK);
        check("tx_start_last", TXD, 1'b0);
        @(negedge PCLK);
        check("tx_start_end", TXD, 1'b1);
        repeat (8) @(negedge PCLK);
        frame = {1'b1, 8'hA5};
        for (int k = 0; k < 9; k++) begin
            check($sformatf("tx_bit%0d", k), TXD, frame[k]);
            repeat (16) @(negedge PCLK);
        end
        repeat (20) @(negedge PCLK);
        status_check("tx_done_status");

        // ---- Loopback of fixed bytes ----
        loop_en = 1;
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hFF; tx_bytes[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            apb_write(3'd0, {24'h0, tx_bytes[i]});
            rxq.push_back(tx_bytes[i]);
        end
        repeat (600) @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            status_check($sformatf("loop_count%0d", i));
            b = rxq.pop_front();
            apb_read(3'd0, d);
            check($sformatf("loop_data%0d", i), d, {24'h0, b});
        end
        status_check("loop_count_end");
        apb_read(3'd0, d); check("empty_read", d, 32'd0);

        // ---- Loopback of random bytes at a random divisor ----
        div_cur = $urandom_range(1, 3);
        apb_write(3'd3, div_cur);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            apb_write(3'd0, {24'h0, b});
            rxq.push_back(b);
        end
        repeat (3 * 160 * (div_cur + 1) + 200) @(negedge PCLK);
        status_check("div_loop_status");
        drain_check("div_loop_data");
        apb_write(3'd3, 32'd0); div_cur = 0;
        loop_en = 0;

        // ---- Overrun: 17 frames into a 16-deep FIFO ----
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1);
        status_check("overrun_status");
        status_check("overrun_cleared");
        drain_check("overrun_data");

        // ---- Glitch and framing error ----
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        @(negedge PCLK); rxd_drv = 1'b0;
        repeat (4) @(negedge PCLK);
        rxd_drv = 1'b1;
        repeat (40) @(negedge PCLK);
        status_check("glitch_status");
        send_frame(8'($urandom), 1'b0);
        status_check("frame_err_status");
        status_check("frame_err_cleared");
        apb_write(3'd4, 32'h1);
        rxq.delete();
        status_check("flush_status");

        // ---- RX threshold interrupt ----
        apb_write(3'd2, 32'h407);
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
        check("irq_below_thr", irq, 1'b0);
        send_frame(8'($urandom), 1'b1);
        check("irq_at_thr", irq, 1'b1);
        b = rxq.pop_front();
        apb_read(3'd0, d);
        check("irq_pop_data", d, {24'h0, b});
        repeat (2) @(negedge PCLK);
        check("irq_after_pop", irq, 1'b0);
        drain_check("irq_drain");

        apb_write(3'd2, 32'h007);
        send_frame(8'($urandom), 1'b1);
        check("irq_thr0", irq, 1'b1);
        drain_check("thr0_data");
        repeat (2) @(negedge PCLK);
        check("irq_thr0_clear", irq, 1'b0);

        apb_write(3'd2, 32'h00B);
        repeat (3) @(negedge PCLK);
        check("irq_tx_empty", irq, 1'b1);
        apb_write(3'd2, 32'h013);
        repeat (3) @(negedge PCLK);
        check("irq_tx_off", irq, 1'b0);
        send_frame(8'($urandom), 1'b0);
        check("irq_err", irq, 1'b1);
        status_check("irq_err_status");
        repeat (2) @(negedge PCLK);
        check("irq_err_clear", irq, 1'b0);

        // ---- Reset during TX data bit 3 ----
        apb_write(3'd2, 32'h3);
        b = 8'($urandom) & 8'hF7;
        apb_write(3'd0, {24'h0, b});
        wait_txd_low("rst_tx_start");
        repeat (16 + 48 + 8) @(negedge PCLK);
        check("rst_bit3_low", TXD, 1'b0);
        #2 PRESET = 1;
        #1 check("rst_txd_async", TXD, 1'b1);
        repeat (2) @(negedge PCLK);
        PRESET = 0;
        rxq.delete(); ovr_m = 0; ferr_m = 0; div_cur = 26;
        @(negedge PCLK);
        check("rst_irq", irq, 1'b0);
        status_check("rst_status");
        apb_read(3'd2, d); check("rst_ctrl", d, 32'd0);
        apb_read(3'd3, d); check("rst_baud", d, 32'd26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
